// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and condition-code bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_HOLD  = 4'd8,
    OP_INC   = 4'd9,
    OP_DEC   = 4'd10,
    OP_NEG   = 4'd11,
    OP_ASR   = 4'd12,
    OP_ROL   = 4'd13,
    OP_ROR   = 4'd14,
    OP_PASSB = 4'd15
  } opcode_t;

  localparam int unsigned CC_N = 3;
  localparam int unsigned CC_Z = 2;
  localparam int unsigned CC_V = 1;
  localparam int unsigned CC_C = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the register file side and the ALU.
interface alu_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   n;
  logic [3:0]   cc;
  logic [W-1:0] tr;

  modport master (output A, output B, output n, input cc, input tr);
  modport slave  (input A, input B, input n, output cc, output tr);
endinterface

// File: rtl/alu_addsub.sv
// Combinational adder computing x + y + 0 or x + ~y + 1, with carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         c,
  output logic         v
);
  logic [W-1:0] y_eff;
  logic [W:0]   full;

  assign y_eff = y ^ {W{sub}};
  assign full  = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
  assign sum   = full[W-1:0];
  assign c     = full[W];
  // Overflow judged on the effective addend, so one rule serves add and subtract.
  assign v     = (x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]);
endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: result and {N,Z,V,C} update on every rising edge except HOLD.
module alu #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);
  import alu_pkg::*;

  opcode_t      op;
  logic [W-1:0] as_x;
  logic [W-1:0] as_y;
  logic         as_sub;
  logic [W-1:0] as_sum;
  logic         as_c;
  logic         as_v;
  logic [W-1:0] res;
  logic         c_next;
  logic         v_next;
  logic         hold;
  logic [3:0]   cc_next;
  logic [W-1:0] tr_q;
  logic [3:0]   cc_q;

  assign op = opcode_t'(bus.n);

  always_comb begin
    as_x   = bus.A;
    as_y   = bus.B;
    as_sub = 1'b0;
    unique case (op)
      OP_SUB: as_sub = 1'b1;
      OP_INC: as_y   = W'(1);
      OP_DEC: begin as_y = W'(1); as_sub = 1'b1; end
      OP_NEG: begin as_x = '0; as_y = bus.A; as_sub = 1'b1; end
      default: ;
    endcase
  end

  alu_addsub #(.W(W)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (as_sub),
    .sum (as_sum),
    .c   (as_c),
    .v   (as_v)
  );

  always_comb begin
    res    = '0;
    c_next = 1'b0;
    v_next = 1'b0;
    hold   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
        res    = as_sum;
        c_next = as_c;
        v_next = as_v;
      end
      OP_AND:   res = bus.A & bus.B;
      OP_OR:    res = bus.A | bus.B;
      OP_XOR:   res = bus.A ^ bus.B;
      OP_NOT:   res = ~bus.A;
      OP_PASSB: res = bus.B;
      OP_SHL: begin res = {bus.A[W-2:0], 1'b0};          c_next = bus.A[W-1]; end
      OP_SHR: begin res = {1'b0, bus.A[W-1:1]};          c_next = bus.A[0];   end
      OP_ASR: begin res = {bus.A[W-1], bus.A[W-1:1]};    c_next = bus.A[0];   end
      OP_ROL: begin res = {bus.A[W-2:0], bus.A[W-1]};    c_next = bus.A[W-1]; end
      OP_ROR: begin res = {bus.A[0], bus.A[W-1:1]};      c_next = bus.A[0];   end
      OP_HOLD:  hold = 1'b1;
      default:  hold = 1'b1;
    endcase
    cc_next       = '0;
    cc_next[CC_N] = res[W-1];
    cc_next[CC_Z] = (res == '0);
    cc_next[CC_V] = v_next;
    cc_next[CC_C] = c_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tr_q <= '0;
      cc_q <= '0;
    end else if (!hold) begin
      tr_q <= res;
      cc_q <= cc_next;
    end
  end

  assign bus.tr = tr_q;
  assign bus.cc = cc_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences, and a randomized model run.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_if #(.W(W)) bus ();

  alu #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tr;
    logic [3:0] cc;
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] cur_tr = '0;
  logic [3:0] cur_cc = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] tr;
    logic [3:0] cc;
    string      name;
  } vec_t;

  vec_t tbl[19];

  // Reference model written in terms of wide integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op, input logic rst,
                                 input exp_t prev);
    exp_t e;
    int   sa, sb, s;
    logic [7:0] r;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    if (rst) return '{tr: 8'h00, cc: 4'b0000};
    case (op)
      4'd0:  begin r = a + b; c = (int'(a) + int'(b)) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      4'd1:  begin r = a - b; c = (a >= b); s = sa - sb; v = (s > 127) || (s < -128); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  begin r = a << 1; c = a[7]; end
      4'd7:  begin r = a >> 1; c = a[0]; end
      4'd8:  return prev;
      4'd9:  begin r = a + 8'd1; c = (a == 8'hFF); v = (sa + 1) > 127; end
      4'd10: begin r = a - 8'd1; c = (a != 8'h00); v = (sa - 1) < -128; end
      4'd11: begin r = 8'd0 - a; c = (a == 8'h00); v = (-sa) > 127; end
      4'd12: begin r = 8'($signed(a) >>> 1); c = a[0]; end
      4'd13: begin r = (a << 1) | (a >> 7); c = a[7]; end
      4'd14: begin r = (a >> 1) | (a << 7); c = a[0]; end
      default: r = b;
    endcase
    e.tr = r;
    e.cc = {r[7], (r == 8'h00), v, c};
    return e;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got tr=%02h cc=%04b, expected tr=%02h cc=%04b",
               name, act[11:4], act[3:0], req[11:4], req[3:0]);
    end
  endtask

  // Drive one cycle at the falling edge, queue the expectation, compare just after the rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic rst, input logic [7:0] etr, input logic [3:0] ecc,
                      input string name);
    exp_t got;
    exp_t want;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.n = op;
    reset = rst;
    sb_q.push_back('{tr: etr, cc: ecc});
    cur_tr = etr;
    cur_cc = ecc;
    @(posedge clk);
    #1;
    got = '{tr: bus.tr, cc: bus.cc};
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got tr=%02h cc=%04b", name, got.tr, got.cc);
    end else begin
      want = sb_q.pop_front();
      check(name, got, want);
    end
  endtask

  task automatic mstep(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic rst, input string name);
    exp_t e;
    e = model(a, b, op, rst, '{tr: cur_tr, cc: cur_cc});
    step(a, b, op, rst, e.tr, e.cc, name);
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners[4];
    corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h7F, 8'h01, OP_ADD,   8'h80, 4'b1010, "add_ovf"};
    tbl[1]  = '{8'h05, 8'h05, OP_SUB,   8'h00, 4'b0101, "sub_equal"};
    tbl[2]  = '{8'h03, 8'h05, OP_SUB,   8'hFE, 4'b1000, "sub_borrow"};
    tbl[3]  = '{8'h81, 8'h00, OP_SHL,   8'h02, 4'b0001, "shl"};
    tbl[4]  = '{8'h81, 8'h00, OP_ASR,   8'hC0, 4'b1001, "asr"};
    tbl[5]  = '{8'h81, 8'h00, OP_ROR,   8'hC0, 4'b1001, "ror"};
    tbl[6]  = '{8'hFF, 8'h01, OP_ADD,   8'h00, 4'b0101, "add_wrap"};
    tbl[7]  = '{8'h81, 8'h00, OP_SHR,   8'h40, 4'b0001, "shr"};
    tbl[8]  = '{8'h81, 8'h00, OP_ROL,   8'h03, 4'b0001, "rol"};
    tbl[9]  = '{8'hF0, 8'h3C, OP_AND,   8'h30, 4'b0000, "and"};
    tbl[10] = '{8'hF0, 8'h0F, OP_OR,    8'hFF, 4'b1000, "or"};
    tbl[11] = '{8'hFF, 8'hFF, OP_XOR,   8'h00, 4'b0100, "xor"};
    tbl[12] = '{8'h00, 8'h55, OP_NOT,   8'hFF, 4'b1000, "not"};
    tbl[13] = '{8'h7F, 8'h00, OP_INC,   8'h80, 4'b1010, "inc_ovf"};
    tbl[14] = '{8'h00, 8'h00, OP_DEC,   8'hFF, 4'b1000, "dec_zero"};
    tbl[15] = '{8'h80, 8'h00, OP_NEG,   8'h80, 4'b1010, "neg_min"};
    tbl[16] = '{8'h00, 8'h00, OP_NEG,   8'h00, 4'b0101, "neg_zero"};
    tbl[17] = '{8'h12, 8'h7F, OP_PASSB, 8'h7F, 4'b0000, "pass_b"};
    tbl[18] = '{8'h80, 8'h01, OP_SUB,   8'h7F, 4'b0011, "sub_ovf"};

    bus.A = '0;
    bus.B = '0;
    bus.n = '0;

    // Reset state, including reset coinciding with HOLD.
    step(8'hAA, 8'h55, OP_ADD,  1'b1, 8'h00, 4'b0000, "reset_add");
    step(8'hFF, 8'hFF, OP_HOLD, 1'b1, 8'h00, 4'b0000, "reset_hold");

    for (int i = 0; i < 19; i++)
      step(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, tbl[i].tr, tbl[i].cc, tbl[i].name);

    // HOLD keeps the previous result and flags.
    step(8'h02, 8'h03, OP_ADD, 1'b0, 8'h05, 4'b0000, "hold_setup");
    for (int i = 0; i < 3; i++)
      step(8'hFF, 8'hFF, OP_HOLD, 1'b0, 8'h05, 4'b0000, "hold");

    // Reset mid-stream, then first result right after release.
    step(8'h7F, 8'h01, OP_ADD, 1'b0, 8'h80, 4'b1010, "pre_reset");
    step(8'h7F, 8'h01, OP_ADD, 1'b1, 8'h00, 4'b0000, "mid_reset");
    step(8'h01, 8'h01, OP_ADD, 1'b0, 8'h02, 4'b0000, "post_reset");

    // Inputs changing between edges must not reach the outputs.
    bus.A = 8'hFF;
    bus.n = OP_NOT;
    #3;
    check("midcycle_stable", {bus.tr, bus.cc}, {8'h02, 4'b0000});

    for (int i = 0; i < 10000; i++) begin
      logic [3:0] op;
      op = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      mstep(pick_operand(), pick_operand(), op, ($urandom_range(0, 63) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: W, default 8, data-path width in bits; all arithmetic rules below scale with W.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 A  input  W  operand A, the register-file read port selected by Abus.
REQ-005 B  input  W  operand B, the register-file read port selected by Bbus.
REQ-006 n  input  4  opcode.
REQ-007 cc  output  4  condition codes {N,Z,V,C}, registered.
REQ-008 tr  output  W  result, registered.

Function
REQ-009 On each rising clk with reset low, tr and cc SHALL be updated from A, B and n of that cycle, giving a latency of 1 cycle with no handshake.
REQ-010 The opcode map SHALL be:
- 0 ADD A+B
- 1 SUB A-B
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 SHL A by 1
- 7 SHR A by 1, logical
- 8 HOLD
- 9 INC A
- 10 DEC A
- 11 NEG A
- 12 ASR A by 1
- 13 ROL A by 1
- 14 ROR A by 1
- 15 PASS B
REQ-011 HOLD (n=8) SHALL leave tr and cc unchanged; this opcode is reserved for the external memory-load path.
REQ-012 ADD/INC: result = low W bits of the sum; C = carry out of bit W-1; V = signed overflow (operands same sign, result sign differs).
REQ-013 SUB/DEC/NEG SHALL be computed as X + ~Y + 1:
- SUB: X=A, Y=B
- DEC: X=A, Y=1
- NEG: X=0, Y=A
- C = carry out, so C=1 means no borrow.
- V = signed overflow of the subtraction.
REQ-014 Logical ops (AND/OR/XOR/NOT/PASS B): C=0, V=0.
REQ-015 Shifts and rotates: C = bit shifted out (bit W-1 for SHL/ROL, bit 0 for SHR/ASR/ROR); V=0.
- ASR replicates bit W-1.
- ROL/ROR move the shifted-out bit into the vacated position.
REQ-016 For every non-HOLD opcode: N = result[W-1]; Z = 1 iff result == 0.
REQ-017 Wrap-around SHALL be modulo 2^W with no saturation: 0xFF+0x01 -> 0x00 with C=1, Z=1.
REQ-018 Operand or opcode changes between edges SHALL have no effect until the next rising edge.

Reset
REQ-019 While reset is high at a rising clk: tr <= 0 and cc <= 4'b0000, regardless of n.
REQ-020 Reset asserted in the same cycle as any opcode, including HOLD, SHALL take priority.
REQ-021 The first computed result SHALL appear on the first rising edge with reset low.

Structure
REQ-022 A shared package SHALL hold:
- the opcode enumeration (4-bit, values per REQ-010)
- the cc bit-index constants (N=3, Z=2, V=1, C=0)
REQ-023 The next-state logic SHALL be a single combinational block feeding one result/flag register.
REQ-024 No sub-module is required; an optional combinational adder sub-module alu_addsub SHALL, if used, serve ADD/SUB/INC/DEC/NEG.

Verification
REQ-025 ADD overflow: A=0x7F, B=0x01, n=0 -> tr=0x80, cc=1010.
REQ-026 SUB equal and borrow:
- A=0x05, B=0x05, n=1 -> tr=0x00, cc=0101.
- A=0x03, B=0x05, n=1 -> tr=0xFE, cc=1000.
REQ-027 Shifts:
- A=0x81, n=6 -> tr=0x02, cc=0001.
- A=0x81, n=12 -> tr=0xC0, cc=1001.
- A=0x81, n=14 -> tr=0xC0, cc=1001.
REQ-028 HOLD: after ADD 0x02+0x03 gives tr=0x05, apply n=8 with A=0xFF, B=0xFF for 3 cycles -> tr stays 0x05, cc stays 0000.
REQ-029 Reset mid-stream: tr=0x80 with cc=1010, then assert reset with n=0 -> next edge tr=0x00, cc=0000; the edge after deassertion shows the new result.
REQ-030 Randomized check: at least 10,000 cycles against a reference model covering all 16 opcodes, including operands 0x00, 0x7F, 0x80 and 0xFF.
